// File: rtl/fqmul_pipe_pkg.sv
// Shared Kyber constants and lane types for the Montgomery multiply pipeline.
package fqmul_pipe_pkg;

   localparam int LANE_W = 16;
   localparam int PROD_W = 2 * LANE_W;
   localparam int KYBER_Q = 3329;

   typedef logic signed [LANE_W-1:0] coef_t;
   typedef logic signed [PROD_W-1:0] prod_t;

   localparam coef_t KYBER_QINV = -16'sd3327;

endpackage

// File: rtl/mont_reduce_pipe.sv
// One lane of Montgomery reduction: S2 registers m and the product, S3 registers t.
module mont_reduce_pipe
   import fqmul_pipe_pkg::*;
#(
   parameter int    Q    = KYBER_Q,
   parameter coef_t QINV = KYBER_QINV
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  en_p2_i,
   input  logic  en_p3_i,
   input  prod_t prod_i,
   output coef_t t_o
);

   localparam prod_t Q_W = PROD_W'(Q);

   function automatic coef_t mont_m(input coef_t p_lo);
      return p_lo * QINV;
   endfunction

   // p - m*Q has its low half cleared by construction, so the shift is exact.
   function automatic coef_t mont_t(input prod_t p, input coef_t m);
      prod_t diff;
      diff = p - m * Q_W;
      return LANE_W'(diff >>> LANE_W);
   endfunction

   prod_t prod_p2_q;
   coef_t m_p2_q;
   coef_t t_p3_q;

   // S2: m and the product
   always_ff @(posedge clk_i) begin
      if (en_p2_i) begin
         prod_p2_q <= prod_i;
         m_p2_q    <= mont_m(prod_i[LANE_W-1:0]);
      end
   end

   // S3: reduced result
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         t_p3_q <= '0;
      end else if (en_p3_i) begin
         t_p3_q <= mont_t(prod_p2_q, m_p2_q);
      end
   end

   assign t_o = t_p3_q;

endmodule

// File: rtl/fqmul_pipe.sv
// Three-stage multi-lane Montgomery multiply (a*b*2^-16 mod Q) with valid/ready flow control.
module fqmul_pipe
   import fqmul_pipe_pkg::*;
#(
   parameter int    LANES = 2,
   parameter int    TAG_W = 4,
   parameter int    Q     = KYBER_Q,
   parameter coef_t QINV  = KYBER_QINV
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANE_W*LANES-1:0] a,
   input  logic [LANE_W*LANES-1:0] b,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANE_W*LANES-1:0] t,
   output logic [TAG_W-1:0]        out_tag
);

   logic vld_p1_q, vld_p2_q, vld_p3_q;
   logic vld_p1_d, vld_p2_d, vld_p3_d;
   logic adv_p1, adv_p2, adv_p3;

   logic [TAG_W-1:0] tag_p1_q, tag_p2_q, tag_p3_q;

   // Each stage moves when the one after it is empty or moving, so bubbles collapse.
   always_comb begin
      adv_p3   = !vld_p3_q || out_ready;
      adv_p2   = !vld_p2_q || adv_p3;
      adv_p1   = !vld_p1_q || adv_p2;
      vld_p1_d = adv_p1 ? in_valid : vld_p1_q;
      vld_p2_d = adv_p2 ? vld_p1_q : vld_p2_q;
      vld_p3_d = adv_p3 ? vld_p2_q : vld_p3_q;
   end

   assign in_ready  = adv_p1;
   assign out_valid = vld_p3_q;
   assign out_tag   = tag_p3_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         vld_p3_q <= vld_p3_d;
      end
   end

   // S1/S2: tag follows its beat
   always_ff @(posedge clk) begin
      if (adv_p1) tag_p1_q <= in_tag;
      if (adv_p2) tag_p2_q <= tag_p1_q;
   end

   // S3: tag visible at the output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_p3_q <= '0;
      end else if (adv_p3) begin
         tag_p3_q <= tag_p2_q;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      coef_t a_l, b_l, t_l;
      prod_t prod_p1_q;

      assign a_l = a[LANE_W*i +: LANE_W];
      assign b_l = b[LANE_W*i +: LANE_W];

      // S1: full signed product
      always_ff @(posedge clk) begin
         if (adv_p1) prod_p1_q <= a_l * b_l;
      end

      mont_reduce_pipe #(
         .Q    (Q),
         .QINV (QINV)
      ) u_reduce (
         .clk_i   (clk),
         .rst_ni  (reset_n),
         .en_p2_i (adv_p2),
         .en_p3_i (adv_p3),
         .prod_i  (prod_p1_q),
         .t_o     (t_l)
      );

      assign t[LANE_W*i +: LANE_W] = t_l;
   end

endmodule

// File: tb/tb_fqmul_pipe.sv
// Randomized bench for fqmul_pipe (4 lanes) against an integer-arithmetic reference.
module tb_fqmul_pipe;

   localparam int L  = 4;
   localparam int TW = 4;
   localparam int LW = 16;
   localparam longint QR    = 3329;
   localparam longint QINVR = -3327;

   typedef logic [LW*L+TW-1:0] res_t;
   typedef logic [2*LW*L-1:0]  opnd_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [LW*L-1:0] a, b, t;
   logic [TW-1:0] in_tag, out_tag;

   res_t  exp_q[$];
   res_t  got_q[$];
   opnd_t in_q[$];
   int    total = 0;
   int    bad   = 0;
   int    n_acc = 0;

   always #5 clk = ~clk;

   fqmul_pipe #(
      .LANES (L),
      .TAG_W (TW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .t         (t),
      .out_tag   (out_tag)
   );

   function automatic logic [LW-1:0] ref_fqmul(input logic signed [LW-1:0] x, input logic signed [LW-1:0] y);
      longint p, m, r;
      p = longint'(x) * longint'(y);
      m = ((p & 64'hFFFF) * QINVR) & 64'hFFFF;
      if (m >= 32768) m = m - 65536;
      r = (p - m * QR) / 65536;
      return LW'(r);
   endfunction

   function automatic res_t ref_beat(input logic [LW*L-1:0] x, input logic [LW*L-1:0] y, input logic [TW-1:0] tg);
      res_t r;
      r[TW-1:0] = tg;
      for (int i = 0; i < L; i++) r[TW+LW*i +: LW] = ref_fqmul(x[LW*i +: LW], y[LW*i +: LW]);
      return r;
   endfunction

   function automatic logic [LW*L-1:0] rand_vec();
      return {$urandom, $urandom};
   endfunction

   task automatic clear_all();
      exp_q.delete();
      got_q.delete();
      in_q.delete();
      n_acc = 0;
   endtask

   // One clock: log accepted beats into the model and consumed results into got_q.
   task automatic tick();
      if (in_valid && in_ready) begin
         exp_q.push_back(ref_beat(a, b, in_tag));
         in_q.push_back({a, b});
         n_acc++;
      end
      if (out_valid && out_ready) got_q.push_back({t, out_tag});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; in_tag = '0;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      total++; if (t !== '0) begin bad++; $display("FAIL reset_t got=%h want=0", t); end
      total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b want=1", in_ready); end
   endtask

   task automatic test_identity();
      clear_all();
      a = rand_vec(); b = rand_vec();
      a[15:0] = 16'd1; b[15:0] = 16'd2285; in_tag = 4'd5;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ident_lat1 got=%0b want=0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ident_lat2 got=%0b want=0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ident_lat3 got=%0b want=1", out_valid); end
      total++; if (t[15:0] !== 16'h0001) begin bad++; $display("FAIL ident_t0 got=%h want=0001", t[15:0]); end
      total++; if (out_tag !== 4'd5) begin bad++; $display("FAIL ident_tag got=%0d want=5", out_tag); end
      total++; if ({t, out_tag} !== exp_q[0]) begin bad++; $display("FAIL ident_lanes got=%h want=%h", {t, out_tag}, exp_q[0]); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ident_consumed got=%0b want=0", out_valid); end
   endtask

   task automatic test_sign();
      int lat;
      clear_all();
      a = rand_vec(); b = rand_vec();
      a[15:0]  = 16'hFFFF; b[15:0]  = 16'd1;
      a[31:16] = 16'd3329; b[31:16] = 16'd7;
      a[47:32] = 16'h8000; b[47:32] = 16'h8000;
      in_tag = 4'hA; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
      total++; if (lat !== 3) begin bad++; $display("FAIL sign_latency got=%0d want=3", lat); end
      total++; if (t[15:0] !== 16'hFF57) begin bad++; $display("FAIL sign_neg got=%h want=ff57", t[15:0]); end
      total++; if (t[31:16] !== 16'h0000) begin bad++; $display("FAIL sign_q_multiple got=%h want=0000", t[31:16]); end
      total++; if (t[47:32] !== 16'h4000) begin bad++; $display("FAIL sign_min_operands got=%h want=4000", t[47:32]); end
      total++; if ({t, out_tag} !== exp_q[0]) begin bad++; $display("FAIL sign_lanes got=%h want=%h", {t, out_tag}, exp_q[0]); end
      tick();
   endtask

   task automatic test_throughput();
      int budget;
      clear_all();
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         a = rand_vec(); b = rand_vec(); in_tag = TW'(i);
         if (i % 17 == 3) begin a[LW*(i%L) +: LW] = 16'h8000; b[LW*(i%L) +: LW] = 16'h8000; end
         in_valid = 1'b1;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL tput_in_ready beat=%0d got=%0b want=1", i, in_ready); end
         tick();
      end
      in_valid = 1'b0;
      budget = 0;
      while (got_q.size() < 100 && budget < 20) begin tick(); budget++; end
      total++; if (got_q.size() !== 100) begin bad++; $display("FAIL tput_count got=%0d want=100", got_q.size()); end
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
         total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL tput_beat%0d got=%h want=%h", j, got_q[j], exp_q[j]); end
         for (int i = 0; i < L; i++) begin
            longint tv, p;
            opnd_t op;
            op = in_q[j];
            tv = longint'($signed(got_q[j][TW+LW*i +: LW]));
            p  = longint'($signed(op[LW*L + LW*i +: LW])) * longint'($signed(op[LW*i +: LW]));
            total++; if ((tv * 65536 - p) % QR != 0) begin bad++; $display("FAIL tput_congruence beat=%0d lane=%0d got=%0d want=a*b*2^-16 mod q", j, i, tv); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [LW*L-1:0] held_t;
      logic [TW-1:0]   held_tag;
      int budget;
      clear_all();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == n_acc) begin a = rand_vec(); b = rand_vec(); in_tag = TW'(k + 1); end
         in_valid = 1'b1;
         tick();
      end
      total++; if (n_acc !== 3) begin bad++; $display("FAIL bp_accepted got=%0d want=3", n_acc); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%0b want=1", out_valid); end
      held_t = t; held_tag = out_tag;
      total++; if ({t, out_tag} !== exp_q[0]) begin bad++; $display("FAIL bp_head got=%h want=%h", {t, out_tag}, exp_q[0]); end
      repeat (3) tick();
      total++; if (t !== held_t || out_tag !== held_tag) begin bad++; $display("FAIL bp_stable got=%h/%h want=%h/%h", t, out_tag, held_t, held_tag); end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_push_pop_ready got=%0b want=1", in_ready); end
      tick();
      in_valid = 1'b0;
      budget = 0;
      while (got_q.size() < 4 && budget < 20) begin tick(); budget++; end
      total++; if (got_q.size() !== 4) begin bad++; $display("FAIL bp_drain_count got=%0d want=4", got_q.size()); end
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
         total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL bp_order%0d got=%h want=%h", j, got_q[j], exp_q[j]); end
      end
   endtask

   task automatic test_reset_midflight();
      int seen, lat;
      clear_all();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a = rand_vec(); b = rand_vec(); in_tag = TW'(9 + k); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%0b want=1", out_valid); end
      #2;
      reset_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%0b want=0", out_valid); end
      total++; if (t !== '0 || out_tag !== '0) begin bad++; $display("FAIL rst_async_data got=%h/%h want=0/0", t, out_tag); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
      clear_all();
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1; out_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         if (out_valid === 1'b1) seen++;
         tick();
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL rst_stale got=%0d want=0", seen); end
      a = rand_vec(); b = rand_vec(); in_tag = 4'h3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
      total++; if (lat !== 3) begin bad++; $display("FAIL rst_new_latency got=%0d want=3", lat); end
      total++; if ({t, out_tag} !== exp_q[0]) begin bad++; $display("FAIL rst_new_value got=%h want=%h", {t, out_tag}, exp_q[0]); end
      tick();
   endtask

   initial begin
      test_reset();
      test_identity();
      test_sign();
      test_throughput();
      test_backpressure();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule

// File: doc/fqmul_pipe.md
FQMUL_PIPE -- requirements
Module: fqmul_pipe

Interface
REQ-001 Parameter LANES, default 2, number of independent multiply lanes processed in lock-step.
REQ-002 Parameter TAG_W, default 4, width of the opaque tag carried alongside each beat.
REQ-003 Parameter Q, default 3329, the modulus.
REQ-004 Parameter QINV, default -3327, signed 16-bit value satisfying Q*QINV = 1 mod 2^16.
REQ-005 Port clk  input  1  the only clock; all flops update on its rising edge.
REQ-006 Port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Port in_valid  input  1  the beat on a/b/in_tag is valid.
REQ-008 Port in_ready  output  1  the block accepts the beat this cycle.
REQ-009 Port a  input  16*LANES  signed 16-bit operand per lane; lane i occupies bits [16i+15:16i].
REQ-010 Port b  input  16*LANES  signed 16-bit operand per lane, packed the same way.
REQ-011 Port in_tag  input  TAG_W  user tag, returned unmodified with the result.
REQ-012 Port out_valid  output  1  t/out_tag hold a valid result.
REQ-013 Port out_ready  input  1  the consumer accepts the result this cycle.
REQ-014 Port t  output  16*LANES  signed 16-bit a*b*2^-16 mod Q per lane, packed the same way.
REQ-015 Port out_tag  output  TAG_W  tag of the beat in t.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both high; a result is consumed when out_valid and out_ready are both high.
REQ-017 Each lane SHALL compute p = a*b as a signed 32-bit product.
REQ-018 Each lane SHALL then compute m = low16(low16(p)*QINV), interpreted as signed.
REQ-019 Each lane SHALL then compute t = (p - m*Q) >>> 16, with an exact signed 32-bit intermediate; the result lies in (-Q, Q).
REQ-020 The pipeline has three register stages: S1 product, S2 m plus product, S3 t.
REQ-021 Latency from acceptance to out_valid SHALL be exactly 3 cycles when not stalled.
REQ-022 Each stage carries a valid bit and the tag; lanes never diverge in timing.
REQ-023 Stall rule: a stage advances when the stage downstream of it is empty or advancing.
REQ-024 S3 advances when out_valid is low or out_ready is high.
REQ-025 in_ready SHALL equal the S1 advance condition, combinational from stage valids and out_ready only, never from in_valid.
REQ-026 Sustained throughput is one beat per cycle while out_ready stays high.
REQ-027 Pipeline bubbles collapse under stall, so 3 beats can be buffered with out_ready low.
REQ-028 A stalled output SHALL hold t and out_tag stable until consumed.
REQ-029 A beat SHALL be accepted in the same cycle S3 is consumed when the pipeline is full (simultaneous push/pop).
REQ-030 Out-of-range operands (e.g. -32768) SHALL be computed exactly, with no saturation.

Reset
REQ-031 With reset_n low, all stage valid bits, out_valid, t and out_tag SHALL be 0 asynchronously.
REQ-032 Reset mid-operation discards all in-flight beats; no result emerges for them after release.
REQ-033 in_ready SHALL be 1 while reset_n is low and on the first cycle after release.

Structure
REQ-034 Q, QINV default values and the lane width constant (16) SHALL live in a shared kyber parameters package.
REQ-035 One sub-module, mont_reduce_pipe, SHALL implement the S2/S3 Montgomery reduction for one lane with an enable input; it is instantiated LANES times.
REQ-036 Valid, tag and handshake logic SHALL be shared in fqmul_pipe, not per lane.

Verification
REQ-037 Identity: lane0 a=1, b=2285, tag=5 -> after 3 cycles, t lane0 = 1 and out_tag = 5.
REQ-038 Sign: a=-1, b=1 -> t = -169; a=3329, b=7 -> t = 0.
REQ-039 Throughput: 100 random back-to-back beats with out_ready=1 -> 100 results in order, matching a golden model, with in_ready constantly high.
REQ-040 Backpressure: hold out_ready=0 and push 4 beats -> exactly 3 accepted and in_ready=0; t stays stable; release out_ready -> results drain in order with no loss or duplication.
REQ-041 Reset mid-flight: assert reset_n low with 2 beats in flight -> out_valid=0 immediately; after release, no stale result and the first new beat appears 3 cycles after acceptance.
REQ-042 Lanes: LANES=4, with each lane fed different operands including a=b=-32768 -> every lane matches the golden model independently.
